bin_thresh_ctrl: RTL and testbench
==================================

Name: bin_thresh_ctrl

Overview:
- Adaptive threshold controller for the binarization stage.
- Accumulates grey-level statistics over each frame of the grey stream and computes the frame mean with a sequential divider.
- Presents the mean as the threshold for the binarizer; the new value takes effect from the next frame.
- Sits beside the binarizer on the grey stream. Its thresh output replaces the fixed threshold constant.

Parameters:
- CNT_W, 19, pixel-counter width; covers 640x480 active pixels.
- SUM_W, 27, luminance-sum width; CNT_W+8.
- THRESH_INIT, 64, threshold after reset and until the first computed value.
- THRESH_MIN, 16, lower clamp (used only with THRESH_CLAMP_EN).
- THRESH_MAX, 240, upper clamp (used only with THRESH_CLAMP_EN).

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- data_gray  in  8  grey pixel; valid when hsync_gray=1
- hsync_gray  in  1  line-valid / pixel-enable
- vsync_gray  in  1  frame sync; rising edge marks frame boundary
- thresh  out  8  current threshold, registered
- thresh_valid  out  1  one-cycle pulse when thresh is updated
- busy  out  1  divider running
- acc_ovf  out  1  sticky for current frame: pixel counter saturated

Behaviour:
- Clock and reset:
  - Single clock, pclk. rst_n is asynchronous, active-low, and clears all state.
  - Reset values: thresh=THRESH_INIT, thresh_valid=0, busy=0, acc_ovf=0, accumulators=0, vs_d=0, FSM=IDLE.
- Edge detect:
  - vs_d registers vsync_gray.
  - fs = vsync_gray & ~vs_d (a single cycle).
- Accumulator (runs independently of the FSM):
  - Each cycle with hsync_gray=1: sum += data_gray, cnt += 1.
  - When cnt reaches all-ones, both sum and cnt hold, and acc_ovf is set.
  - On an fs cycle: sum<=(hsync_gray?data_gray:0), cnt<=(hsync_gray?1:0), acc_ovf<=0. The boundary pixel belongs to the new frame.
- FSM states: IDLE, DIV, UPD.
  - IDLE:
    - On fs with cnt!=0: snapshot num<=sum and den<=cnt, clear quotient, k<=7, go to DIV.
    - On fs with cnt==0: stay in IDLE; thresh holds; no pulse.
  - DIV (busy=1): restoring division, one quotient bit per cycle for k=7..0.
    - If num >= (den<<k): num -= den<<k and q[k]=1.
    - After k=0, go to UPD. DIV lasts 8 cycles.
  - UPD:
    - thresh<=q and thresh_valid<=1 for exactly one cycle, then go to IDLE.
    - Result is floor(sum/cnt). It is always <=255 because every pixel is <=255, so 8 quotient bits suffice.
  - A new fs while in DIV or UPD aborts the current computation, takes a new snapshot and restarts DIV. The aborted result is never written and produces no pulse.
- Latency:
  - fs detected in cycle N.
  - DIV occupies cycles N+1..N+8; UPD is cycle N+9.
  - thresh changes and thresh_valid is high in cycle N+10, as seen by downstream logic.
- Frame alignment:
  - The threshold computed from frame F is applied to frame F+1 and later.
  - The value changes during the frame-start blanking interval; the binarizer samples thresh freely.
- Arithmetic:
  - All comparisons are unsigned.
  - The shifted divisor is compared at SUM_W+1 bits, so den<<7 never truncates.
- Mid-operation reset: immediate return to the reset values; a partial division is discarded.

Optional Feature:
- Macro: THRESH_CLAMP_EN.
- Defined: the UPD value is clamped, thresh<=min(max(q,THRESH_MIN),THRESH_MAX). This protects against all-black and all-white scenes. The pulse still fires.
- Undefined: thresh<=q unclamped; THRESH_MIN and THRESH_MAX are unused.

Test Plan:
- Reset -> thresh=64, thresh_valid=0, busy=0. Hold rst_n low mid-DIV -> all outputs return to reset values within the same cycle (async).
- Frame of 4 valid pixels {100,100,100,100}, then a vsync rising edge -> busy high for 8 cycles; thresh=100 with a 1-cycle thresh_valid exactly 10 cycles after the fs cycle.
- Frame {0,255,10,11} (sum 276, cnt 4) -> thresh=69 (floor).
- Frame with hsync_gray never high, then vsync edge -> no thresh_valid, thresh keeps its previous value.
- Two vsync edges 4 cycles apart, first frame mean 200, second frame 3 pixels of 30 -> a single thresh_valid pulse, thresh=30; 200 is never output.
- THRESH_CLAMP_EN defined, frame of all 0 -> thresh=16; frame of all 255 -> thresh=240. Undefined -> 0 and 255 respectively.

Source files
------------

// File: rtl/bin_thresh_ctrl.sv
// bin_thresh_ctrl: per-frame mean of the grey stream, used as the binarizer threshold; define THRESH_CLAMP_EN to clamp the result
module bin_thresh_ctrl #(
    parameter int         CNT_W       = 19,
    parameter int         SUM_W       = 27,
    parameter logic [7:0] THRESH_INIT = 8'd64
`ifdef THRESH_CLAMP_EN
    ,
    parameter logic [7:0] THRESH_MIN  = 8'd16,
    parameter logic [7:0] THRESH_MAX  = 8'd240
`endif
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic [7:0] data_gray,
    input  logic       hsync_gray,
    input  logic       vsync_gray,
    output logic [7:0] thresh,
    output logic       thresh_valid,
    output logic       busy,
    output logic       acc_ovf
);
    typedef enum logic [1:0] {IDLE, DIV, UPD} state_t;

    state_t           state, state_nxt;
    logic             vs_d;
    logic             fs;
    logic [SUM_W-1:0] sum, num;
    logic [CNT_W-1:0] cnt, den;
    logic [7:0]       q, res;
    logic [2:0]       k;
    logic [SUM_W:0]   dsh;
    logic             ge;

    assign fs   = vsync_gray & ~vs_d;
    assign dsh  = (SUM_W+1)'(den) << k;
    assign ge   = {1'b0, num} >= dsh;
    assign busy = state == DIV;
`ifdef THRESH_CLAMP_EN
    assign res  = q < THRESH_MIN ? THRESH_MIN : (q > THRESH_MAX ? THRESH_MAX : q);
`else
    assign res  = q;
`endif

    // vsync delay for frame-start edge detection
    always_ff @(posedge pclk or negedge rst_n)
        if (!rst_n) vs_d <= 1'b0;
        else        vs_d <= vsync_gray;

    // frame statistics; the boundary pixel starts the new frame, counter saturation freezes both
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            cnt     <= '0;
            acc_ovf <= 1'b0;
        end else if (fs) begin
            sum     <= hsync_gray ? SUM_W'(data_gray) : '0;
            cnt     <= hsync_gray ? CNT_W'(1) : '0;
            acc_ovf <= 1'b0;
        end else if (hsync_gray) begin
            if (&cnt) begin
                acc_ovf <= 1'b1;
            end else begin
                sum <= sum + SUM_W'(data_gray);
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // state register
    always_ff @(posedge pclk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // next state: any frame start restarts (or cancels, on an empty frame) the division
    always_comb begin
        state_nxt = state;
        if (fs)
            state_nxt = cnt != '0 ? DIV : IDLE;
        else if (state == DIV)
            state_nxt = k == 3'd0 ? UPD : DIV;
        else if (state == UPD)
            state_nxt = IDLE;
    end

    // restoring divider: snapshot at frame start, then one quotient bit per cycle MSB first
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            num <= '0;
            den <= '0;
            q   <= '0;
            k   <= '0;
        end else if (fs && cnt != '0) begin
            num <= sum;
            den <= cnt;
            q   <= '0;
            k   <= 3'd7;
        end else if (state == DIV) begin
            if (ge) begin
                num  <= num - dsh[SUM_W-1:0];
                q[k] <= 1'b1;
            end
            k <= k - 3'd1;
        end
    end

    // publish the quotient unless a frame start aborted it in the same cycle
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            thresh       <= THRESH_INIT;
            thresh_valid <= 1'b0;
        end else begin
            thresh_valid <= state == UPD && !fs;
            if (state == UPD && !fs) thresh <= res;
        end
    end
endmodule

// File: tb/tb_bin_thresh_ctrl.sv
// tb_bin_thresh_ctrl: scoreboard bench for the adaptive threshold controller
module tb_bin_thresh_ctrl;
    logic       pclk = 1'b0;
    logic       rst_n;
    logic [7:0] data_gray;
    logic       hsync_gray;
    logic       vsync_gray;
    logic [7:0] thresh;
    logic       thresh_valid;
    logic       busy;
    logic       acc_ovf;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   msum, mcnt, exp_th, busy_from, busy_until;
    bit   vs_m, exp_tv;

    bin_thresh_ctrl dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .data_gray   (data_gray),
        .hsync_gray  (hsync_gray),
        .vsync_gray  (vsync_gray),
        .thresh      (thresh),
        .thresh_valid(thresh_valid),
        .busy        (busy),
        .acc_ovf     (acc_ovf)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int clampv(input int v);
`ifdef THRESH_CLAMP_EN
        return v < 16 ? 16 : (v > 240 ? 240 : v);
`else
        return v;
`endif
    endfunction

    // reference model and scoreboard, evaluated mid-cycle
    always @(negedge pclk) begin
        if (!rst_n) begin
            sb.delete();
            msum       = 0;
            mcnt       = 0;
            exp_th     = 64;
            busy_from  = 1;
            busy_until = 0;
            vs_m       = 1'b0;
        end else begin
            exp_tv = sb.size() > 0 && sb[0].cyc == cyc;
            if (exp_tv) begin
                exp_th = sb[0].val;
                void'(sb.pop_front());
            end
            chk("thresh_valid", int'(thresh_valid), int'(exp_tv));
            chk("thresh", int'(thresh), exp_th);
            chk("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_until));
            chk("acc_ovf", int'(acc_ovf), 0);
            if (vsync_gray && !vs_m) begin
                sb.delete();
                if (mcnt != 0) begin
                    sb.push_back('{clampv(msum / mcnt), cyc + 10});
                    busy_from  = cyc + 1;
                    busy_until = cyc + 8;
                end else if (busy_until > cyc) begin
                    busy_until = cyc;
                end
                msum = hsync_gray ? int'(data_gray) : 0;
                mcnt = hsync_gray ? 1 : 0;
            end else if (hsync_gray) begin
                msum += int'(data_gray);
                mcnt++;
            end
            vs_m = vsync_gray;
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic px(input int d);
        vsync_gray = 1'b0;
        hsync_gray = 1'b1;
        data_gray  = 8'(d);
        tick();
        hsync_gray = 1'b0;
    endtask

    task automatic gap(input int n);
        vsync_gray = 1'b0;
        hsync_gray = 1'b0;
        repeat (n) tick();
    endtask

    task automatic vs();
        hsync_gray = 1'b0;
        vsync_gray = 1'b1;
        tick();
        vsync_gray = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        data_gray  = '0;
        hsync_gray = 1'b0;
        vsync_gray = 1'b0;
        repeat (3) tick();
        chk("rst_thresh", int'(thresh), 64);
        chk("rst_valid", int'(thresh_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(acc_ovf), 0);
        rst_n = 1'b1;
        gap(2);
        repeat (4) px(100);
        gap(2); vs(); gap(12);
        px(0); px(255); px(10); px(11);
        gap(2); vs(); gap(12);
        gap(5); vs(); gap(12);
        px(200); px(200);
        gap(2); vs();
        px(30); px(30); px(30);
        vs(); gap(12);
        for (int i = 0; i < 4; i++) begin
            int n;
            n = int'($urandom_range(1, 12));
            for (int j = 0; j < n; j++) px(int'($urandom_range(0, 255)));
            gap(2); vs(); gap(12);
        end
        repeat (4) px(0);
        gap(2); vs(); gap(12);
        repeat (4) px(255);
        gap(2); vs(); gap(12);
        px(50); px(50);
        gap(1); vs(); gap(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_thresh", int'(thresh), 64);
        chk("async_valid", int'(thresh_valid), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_ovf", int'(acc_ovf), 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) px(120);
        gap(2); vs(); gap(14);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
